// File: rtl/fpu_request_engine.sv
// Request sequencer between the FPU controller and memory: streams strided rows into the
// read buffer, then drains rows from the write buffer back out to memory.
module fpu_request_engine #(
    parameter int unsigned COL_WIDTH        = 10,
    parameter int unsigned MEM_BUFFER_WIDTH = 512
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                read,
    input  logic                                write,
    input  logic [31:0]                         read_address,
    input  logic [31:0]                         write_address,
    input  logic [$clog2(MEM_BUFFER_WIDTH):0]   width,
    input  logic [$clog2(COL_WIDTH):0]          height,
    input  logic [18:0]                         input_row_width,
    input  logic [18:0]                         output_row_width,
    output logic                                making_request,
    output logic                                mem_req,
    output logic                                mem_we,
    output logic [31:0]                         mem_addr,
    output logic [63:0]                         mem_be,
    output logic [511:0]                        mem_wdata,
    input  logic                                mem_ack,
    input  logic [511:0]                        mem_rdata,
    input  logic                                mem_rvalid,
    output logic                                buf_wr_en,
    output logic [$clog2(COL_WIDTH)-1:0]        buf_wr_row,
    output logic [2:0]                          buf_wr_beat,
    output logic [511:0]                        buf_wr_data,
    output logic                                buf_rd_en,
    output logic [$clog2(COL_WIDTH)-1:0]        buf_rd_row,
    output logic [2:0]                          buf_rd_beat,
    input  logic [511:0]                        buf_rd_data
);

    localparam int unsigned WidthW  = $clog2(MEM_BUFFER_WIDTH) + 1;
    localparam int unsigned HeightW = $clog2(COL_WIDTH) + 1;
    localparam int unsigned RowW    = $clog2(COL_WIDTH);

    localparam logic [WidthW-1:0]  WidthMax  = WidthW'(MEM_BUFFER_WIDTH);
    localparam logic [HeightW-1:0] HeightMax = HeightW'(COL_WIDTH - 2);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StWrFetch,
        StWrCap,
        StWrReq,
        StFinish
    } state_e;

    state_e               state_q, state_d;
    logic                 making_request_q, making_request_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [511:0]         mem_wdata_q, mem_wdata_d;
    logic                 buf_wr_en_q, buf_wr_en_d;
    logic [RowW-1:0]      buf_wr_row_q, buf_wr_row_d;
    logic [2:0]           buf_wr_beat_q, buf_wr_beat_d;
    logic [511:0]         buf_wr_data_q, buf_wr_data_d;
    logic                 buf_rd_en_q, buf_rd_en_d;
    logic [HeightW-1:0]   row_q, row_d;
    logic [2:0]           beat_q, beat_d;
    logic [31:0]          row_base_q, row_base_d;
    logic [WidthW-1:0]    width_q, width_d;
    logic [HeightW-1:0]   height_q, height_d;
    logic                 wr_go_q, wr_go_d;
    logic [31:0]          wr_addr_q, wr_addr_d;
    logic [18:0]          in_stride_q, in_stride_d;
    logic [18:0]          out_stride_q, out_stride_d;
    logic                 req_prev_q, req_prev_d;
    logic                 armed_q, armed_d;

    logic                 req_lvl;
    logic                 accept;
    logic [WidthW-1:0]    width_c;
    logic [HeightW-1:0]   height_c;
    logic [WidthW-1:0]    width_m1;
    logic                 last_beat;
    logic [63:0]          be_tail;

    assign req_lvl  = read | write;
    // armed_q blocks a level that was already high when reset released
    assign accept   = (state_q == StIdle) && req_lvl && !req_prev_q && armed_q;
    assign width_c  = (width > WidthMax) ? WidthMax : width;
    assign height_c = (height > HeightMax) ? HeightMax : height;

    // Last beat when 64*beat equals the 64-byte-aligned floor of (width-1)
    assign width_m1  = width_q - WidthW'(1);
    assign last_beat = (WidthW'({beat_q, 6'd0}) == (width_m1 & ~WidthW'(63)));
    assign be_tail   = (64'd1 << width_q[5:0]) - 64'd1;

    always_comb begin
        state_d          = state_q;
        making_request_d = making_request_q;
        mem_wdata_d      = mem_wdata_q;
        buf_wr_en_d      = 1'b0;
        buf_wr_row_d     = buf_wr_row_q;
        buf_wr_beat_d    = buf_wr_beat_q;
        buf_wr_data_d    = buf_wr_data_q;
        row_d            = row_q;
        beat_d           = beat_q;
        row_base_d       = row_base_q;
        width_d          = width_q;
        height_d         = height_q;
        wr_go_d          = wr_go_q;
        wr_addr_d        = wr_addr_q;
        in_stride_d      = in_stride_q;
        out_stride_d     = out_stride_q;
        req_prev_d       = req_lvl;
        armed_d          = armed_q | ~req_lvl;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    width_d          = width_c;
                    height_d         = height_c;
                    wr_go_d          = write && (width_c != '0) && (height_c != '0);
                    wr_addr_d        = write_address;
                    in_stride_d      = input_row_width;
                    out_stride_d     = output_row_width;
                    row_d            = '0;
                    beat_d           = '0;
                    making_request_d = 1'b1;
                    if (read && (width_c != '0)) begin
                        state_d    = StRdReq;
                        row_base_d = read_address;
                    end else if (write && (width_c != '0) && (height_c != '0)) begin
                        state_d    = StWrFetch;
                        row_base_d = write_address;
                    end else begin
                        state_d = StFinish;
                    end
                end
            end
            StRdReq: begin
                if (mem_ack) state_d = StRdWait;
            end
            StRdWait: begin
                if (mem_rvalid) begin
                    buf_wr_en_d   = 1'b1;
                    buf_wr_row_d  = row_q[RowW-1:0];
                    buf_wr_beat_d = beat_q;
                    buf_wr_data_d = mem_rdata;
                    if (!last_beat) begin
                        beat_d  = beat_q + 3'd1;
                        state_d = StRdReq;
                    end else begin
                        beat_d = '0;
                        // The read phase covers height+2 rows
                        if (row_q == height_q + HeightW'(1)) begin
                            row_d = '0;
                            if (wr_go_q) begin
                                state_d    = StWrFetch;
                                row_base_d = wr_addr_q;
                            end else begin
                                state_d = StFinish;
                            end
                        end else begin
                            row_d      = row_q + HeightW'(1);
                            row_base_d = row_base_q + {13'd0, in_stride_q};
                            state_d    = StRdReq;
                        end
                    end
                end
            end
            StWrFetch: begin
                state_d = StWrCap;
            end
            StWrCap: begin
                mem_wdata_d = buf_rd_data;
                state_d     = StWrReq;
            end
            StWrReq: begin
                if (mem_ack) begin
                    if (!last_beat) begin
                        beat_d  = beat_q + 3'd1;
                        state_d = StWrFetch;
                    end else begin
                        beat_d = '0;
                        if (row_q == height_q - HeightW'(1)) begin
                            row_d   = '0;
                            state_d = StFinish;
                        end else begin
                            row_d      = row_q + HeightW'(1);
                            row_base_d = row_base_q + {13'd0, out_stride_q};
                            state_d    = StWrFetch;
                        end
                    end
                end
            end
            StFinish: begin
                state_d          = StIdle;
                making_request_d = 1'b0;
            end
            default: begin
                state_d          = StIdle;
                making_request_d = 1'b0;
            end
        endcase

        mem_req_d   = (state_d == StRdReq) || (state_d == StWrReq);
        mem_we_d    = (state_d == StWrReq);
        buf_rd_en_d = (state_d == StWrFetch);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StIdle;
            making_request_q <= 1'b0;
            mem_req_q        <= 1'b0;
            mem_we_q         <= 1'b0;
            mem_wdata_q      <= '0;
            buf_wr_en_q      <= 1'b0;
            buf_wr_row_q     <= '0;
            buf_wr_beat_q    <= '0;
            buf_wr_data_q    <= '0;
            buf_rd_en_q      <= 1'b0;
            row_q            <= '0;
            beat_q           <= '0;
            row_base_q       <= '0;
            width_q          <= '0;
            height_q         <= '0;
            wr_go_q          <= 1'b0;
            wr_addr_q        <= '0;
            in_stride_q      <= '0;
            out_stride_q     <= '0;
            req_prev_q       <= 1'b0;
            armed_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            making_request_q <= making_request_d;
            mem_req_q        <= mem_req_d;
            mem_we_q         <= mem_we_d;
            mem_wdata_q      <= mem_wdata_d;
            buf_wr_en_q      <= buf_wr_en_d;
            buf_wr_row_q     <= buf_wr_row_d;
            buf_wr_beat_q    <= buf_wr_beat_d;
            buf_wr_data_q    <= buf_wr_data_d;
            buf_rd_en_q      <= buf_rd_en_d;
            row_q            <= row_d;
            beat_q           <= beat_d;
            row_base_q       <= row_base_d;
            width_q          <= width_d;
            height_q         <= height_d;
            wr_go_q          <= wr_go_d;
            wr_addr_q        <= wr_addr_d;
            in_stride_q      <= in_stride_d;
            out_stride_q     <= out_stride_d;
            req_prev_q       <= req_prev_d;
            armed_q          <= armed_d;
        end
    end

    // Address and byte enables are only driven while a request is presented
    assign mem_addr = mem_req_q ? (row_base_q + {23'd0, beat_q, 6'd0}) : 32'd0;
    assign mem_be   = !mem_req_q ? 64'd0 :
                      (last_beat && (width_q[5:0] != 6'd0)) ? be_tail : {64{1'b1}};

    assign making_request = making_request_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_wdata      = mem_wdata_q;
    assign buf_wr_en      = buf_wr_en_q;
    assign buf_wr_row     = buf_wr_row_q;
    assign buf_wr_beat    = buf_wr_beat_q;
    assign buf_wr_data    = buf_wr_data_q;
    assign buf_rd_en      = buf_rd_en_q;
    assign buf_rd_row     = row_q[RowW-1:0];
    assign buf_rd_beat    = beat_q;

endmodule

// File: tb/tb_fpu_request_engine.sv
// Randomised bench for fpu_request_engine: memory and buffer responders plus a
// transaction-list reference model built from the row/beat addressing rules.
module tb_fpu_request_engine;

    typedef struct {
        logic [31:0]  addr;
        logic [63:0]  be;
        logic         we;
        logic [511:0] wdata;
    } tx_t;

    typedef struct {
        int           row;
        int           beat;
        logic [511:0] data;
    } bw_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         read = 1'b0, write = 1'b0;
    logic [31:0]  read_address = '0, write_address = '0;
    logic [9:0]   width = '0;
    logic [4:0]   height = '0;
    logic [18:0]  input_row_width = '0, output_row_width = '0;
    logic         making_request, mem_req, mem_we;
    logic [31:0]  mem_addr;
    logic [63:0]  mem_be;
    logic [511:0] mem_wdata;
    logic         mem_ack = 1'b0;
    logic [511:0] mem_rdata = '0;
    logic         mem_rvalid = 1'b0;
    logic         buf_wr_en, buf_rd_en;
    logic [3:0]   buf_wr_row, buf_rd_row;
    logic [2:0]   buf_wr_beat, buf_rd_beat;
    logic [511:0] buf_wr_data;
    logic [511:0] buf_rd_data = '0;

    int checks = 0;
    int errors = 0;

    tx_t obs_tx[$], exp_tx[$];
    bw_t obs_bw[$], exp_bw[$];

    int           ack_delay = 0;
    int           wait_cnt = 0;
    int           unstable = 0;
    int           idle_viol = 0;
    int           mr_rises = 0, mr_falls = 0, mr_high = 0;
    logic         mr_prev = 1'b0;
    logic         rv_pend = 1'b0, rd_pend = 1'b0;
    logic [31:0]  rv_addr;
    int           rd_row_l, rd_beat_l;
    logic [31:0]  hold_addr;
    logic [63:0]  hold_be;
    logic [511:0] hold_wd;

    fpu_request_engine dut (
        .clk              (clk),
        .rst              (rst),
        .read             (read),
        .write            (write),
        .read_address     (read_address),
        .write_address    (write_address),
        .width            (width),
        .height           (height),
        .input_row_width  (input_row_width),
        .output_row_width (output_row_width),
        .making_request   (making_request),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_be           (mem_be),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .mem_rvalid       (mem_rvalid),
        .buf_wr_en        (buf_wr_en),
        .buf_wr_row       (buf_wr_row),
        .buf_wr_beat      (buf_wr_beat),
        .buf_wr_data      (buf_wr_data),
        .buf_rd_en        (buf_rd_en),
        .buf_rd_row       (buf_rd_row),
        .buf_rd_beat      (buf_rd_beat),
        .buf_rd_data      (buf_rd_data)
    );

    always #5 clk = ~clk;

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [511:0] fdata(input logic [31:0] a);
        logic [31:0] v;
        v = a ^ 32'h5A5A_A5A5;
        return {16{v}};
    endfunction

    function automatic logic [511:0] gdata(input int r, input int b);
        logic [31:0] v;
        v = 32'hB0F0_0000 ^ (r * 256) ^ b;
        return {16{v}};
    endfunction

    // Memory and buffer responders, plus protocol monitors; all act on the falling edge
    always @(negedge clk) begin
        if (making_request && !mr_prev) mr_rises++;
        if (!making_request && mr_prev) mr_falls++;
        if (making_request) mr_high++;
        mr_prev = making_request;
        if (!making_request && (mem_req || buf_wr_en || buf_rd_en)) idle_viol++;
        if (rst) begin
            mem_ack = 1'b0; mem_rvalid = 1'b0; rv_pend = 1'b0; rd_pend = 1'b0;
            wait_cnt = 0; buf_rd_data = '0;
        end else begin
            if (buf_wr_en) begin
                bw_t e;
                e.row = int'(buf_wr_row); e.beat = int'(buf_wr_beat); e.data = buf_wr_data;
                obs_bw.push_back(e);
            end
            buf_rd_data = rd_pend ? gdata(rd_row_l, rd_beat_l) : rnd512();
            rd_pend = buf_rd_en;
            if (buf_rd_en) begin rd_row_l = int'(buf_rd_row); rd_beat_l = int'(buf_rd_beat); end
            mem_rvalid = 1'b0;
            mem_rdata  = rnd512();
            if (rv_pend) begin mem_rvalid = 1'b1; mem_rdata = fdata(rv_addr); rv_pend = 1'b0; end
            mem_ack = 1'b0;
            if (mem_req) begin
                if (wait_cnt == 0) begin
                    hold_addr = mem_addr; hold_be = mem_be; hold_wd = mem_wdata;
                end else if (mem_addr !== hold_addr || mem_be !== hold_be || mem_wdata !== hold_wd) begin
                    unstable++;
                end
                if (wait_cnt == ack_delay) begin
                    tx_t t;
                    t.addr = mem_addr; t.be = mem_be; t.we = mem_we; t.wdata = mem_wdata;
                    obs_tx.push_back(t);
                    mem_ack = 1'b1;
                    if (!mem_we) begin rv_pend = 1'b1; rv_addr = mem_addr; end
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Reference: enumerate every expected memory transaction and buffer load
    task automatic build_model(input bit rd, input bit wr, input logic [31:0] ra,
                               input logic [31:0] wa, input int w, input int h,
                               input int irw, input int orw);
        int wc, hc, beats, rem;
        exp_tx.delete(); exp_bw.delete();
        wc = (w > 512) ? 512 : w;
        hc = (h > 8) ? 8 : h;
        beats = (wc + 63) / 64;
        rem = wc % 64;
        for (int ph = 0; ph < 2; ph++) begin
            int rows;
            if (ph == 0) rows = (rd && wc != 0) ? hc + 2 : 0;
            else         rows = (wr && wc != 0 && hc != 0) ? hc : 0;
            for (int r = 0; r < rows; r++) begin
                for (int b = 0; b < beats; b++) begin
                    tx_t t;
                    logic [31:0] base;
                    base = (ph == 0) ? ra + 32'(r) * 32'(irw) : wa + 32'(r) * 32'(orw);
                    t.addr = base + 32'(64 * b);
                    t.be = '1;
                    if (b == beats - 1 && rem != 0)
                        for (int k = 0; k < 64; k++) t.be[k] = (k < rem);
                    t.we = (ph == 1);
                    t.wdata = (ph == 1) ? gdata(r, b) : '0;
                    exp_tx.push_back(t);
                    if (ph == 0) begin
                        bw_t e;
                        e.row = r; e.beat = b; e.data = fdata(t.addr);
                        exp_bw.push_back(e);
                    end
                end
            end
        end
    endtask

    task automatic diff_results(output int bad_tx, output int bad_bw);
        bad_tx = 0; bad_bw = 0;
        for (int i = 0; i < obs_tx.size() && i < exp_tx.size(); i++)
            if (obs_tx[i].addr !== exp_tx[i].addr || obs_tx[i].be !== exp_tx[i].be ||
                obs_tx[i].we !== exp_tx[i].we ||
                (exp_tx[i].we && obs_tx[i].wdata !== exp_tx[i].wdata)) bad_tx++;
        for (int i = 0; i < obs_bw.size() && i < exp_bw.size(); i++)
            if (obs_bw[i].row !== exp_bw[i].row || obs_bw[i].beat !== exp_bw[i].beat ||
                obs_bw[i].data !== exp_bw[i].data) bad_bw++;
    endtask

    task automatic run_request(input bit rd, input bit wr, input logic [31:0] ra,
                               input logic [31:0] wa, input int w, input int h,
                               input int irw, input int orw, input int dly,
                               input int hold_extra, output bit timed_out);
        @(negedge clk);
        obs_tx.delete(); obs_bw.delete();
        ack_delay = dly; unstable = 0; idle_viol = 0;
        mr_rises = 0; mr_falls = 0; mr_high = 0;
        read_address = ra; write_address = wa;
        width = 10'(w); height = 5'(h);
        input_row_width = 19'(irw); output_row_width = 19'(orw);
        read = rd; write = wr;
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (mr_falls > 0) begin timed_out = 1'b0; break; end
        end
        repeat (hold_extra) @(negedge clk);
        read = 1'b0; write = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({making_request, mem_req, mem_we, buf_wr_en, buf_rd_en} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {making_request, mem_req, mem_we, buf_wr_en, buf_rd_en});
        end
        checks++;
        if (mem_addr !== 32'd0 || mem_be !== 64'd0 || mem_wdata !== 512'd0) begin
            errors++;
            $display("FAIL reset_bus: addr %h be %h want zeros", mem_addr, mem_be);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        bit to; int bt, bb;
        run_request(1, 0, 32'h1000_0000, 32'h0, 130, 8, 390, 0, 0, 10, to);
        build_model(1, 0, 32'h1000_0000, 32'h0, 130, 8, 390, 0);
        diff_results(bt, bb);
        checks++; if (to) begin errors++; $display("FAIL read_timeout: request never finished"); end
        checks++; if (obs_tx.size() !== 30) begin
            errors++; $display("FAIL read_count: got %0d want 30", obs_tx.size()); end
        checks++; if (bt !== 0) begin errors++; $display("FAIL read_tx: %0d bad want 0", bt); end
        checks++; if (obs_tx.size() > 3 && obs_tx[3].addr !== 32'h1000_0186) begin
            errors++; $display("FAIL read_row1_addr: got %h want 10000186", obs_tx[3].addr); end
        checks++; if (obs_tx.size() > 2 && obs_tx[2].be !== 64'h3) begin
            errors++; $display("FAIL read_last_be: got %h want 3", obs_tx[2].be); end
        checks++; if (obs_bw.size() !== 30 || bb !== 0) begin
            errors++; $display("FAIL read_bufwr: got %0d (%0d bad) want 30 (0)", obs_bw.size(), bb); end
        checks++; if (mr_rises !== 1) begin
            errors++; $display("FAIL read_single_req: got %0d want 1", mr_rises); end
        checks++; if (idle_viol !== 0) begin
            errors++; $display("FAIL read_idle_strobe: got %0d want 0", idle_viol); end
    endtask

    task automatic test_write();
        bit to; int bt, bb;
        run_request(0, 1, 32'h0, 32'h2000_0000, 64, 8, 0, 388, 0, 0, to);
        build_model(0, 1, 32'h0, 32'h2000_0000, 64, 8, 0, 388);
        diff_results(bt, bb);
        checks++; if (to || obs_tx.size() !== 8) begin
            errors++; $display("FAIL write_count: got %0d want 8", obs_tx.size()); end
        checks++; if (bt !== 0) begin errors++; $display("FAIL write_tx: %0d bad want 0", bt); end
        checks++; if (obs_tx.size() > 7 && obs_tx[7].addr !== 32'h2000_0A9C) begin
            errors++; $display("FAIL write_row7_addr: got %h want 20000a9c", obs_tx[7].addr); end
        checks++; if (obs_bw.size() !== 0) begin
            errors++; $display("FAIL write_no_bufwr: got %0d want 0", obs_bw.size()); end
    endtask

    task automatic test_read_write();
        bit to; int bt, bb;
        run_request(1, 1, 32'h0300_0040, 32'h0400_0000, 512, 2, 4096, 1024, 0, 0, to);
        build_model(1, 1, 32'h0300_0040, 32'h0400_0000, 512, 2, 4096, 1024);
        diff_results(bt, bb);
        checks++; if (to || obs_tx.size() !== 48) begin
            errors++; $display("FAIL rw_count: got %0d want 48", obs_tx.size()); end
        checks++; if (bt !== 0 || bb !== 0 || obs_bw.size() !== 32) begin
            errors++; $display("FAIL rw_data: tx bad %0d bw bad %0d bw %0d want 0 0 32", bt, bb,
                               obs_bw.size()); end
        checks++; if (mr_rises !== 1 || mr_falls !== 1) begin
            errors++; $display("FAIL rw_busy: rises %0d falls %0d want 1 1", mr_rises, mr_falls); end
    endtask

    task automatic test_ack_delay();
        bit to; int bt, bb;
        run_request(1, 1, 32'h0000_1F00, 32'h8000_0000, 100, 3, 200, 300, 5, 0, to);
        build_model(1, 1, 32'h0000_1F00, 32'h8000_0000, 100, 3, 200, 300);
        diff_results(bt, bb);
        checks++; if (to || unstable !== 0) begin
            errors++; $display("FAIL delay_stable: got %0d changes want 0", unstable); end
        checks++; if (obs_tx.size() !== exp_tx.size() || bt !== 0) begin
            errors++; $display("FAIL delay_tx: got %0d (%0d bad) want %0d", obs_tx.size(), bt,
                               exp_tx.size()); end
        checks++; if (obs_bw.size() !== exp_bw.size() || bb !== 0) begin
            errors++; $display("FAIL delay_bufwr: got %0d (%0d bad) want %0d", obs_bw.size(), bb,
                               exp_bw.size()); end
    endtask

    task automatic test_reset_mid();
        bit to, hit; int bt, bb;
        @(negedge clk);
        obs_tx.delete(); obs_bw.delete(); ack_delay = 0;
        read_address = 32'h0500_0000; width = 10'd256; height = 5'd4;
        input_row_width = 19'd1000; read = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (obs_bw.size() == 3 && mem_req) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach: 4th beat not seen"); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({making_request, mem_req, mem_we, buf_wr_en, buf_rd_en} !== 5'b0 ||
            mem_addr !== 32'd0 || mem_be !== 64'd0 || mem_wdata !== 512'd0) begin
            errors++;
            $display("FAIL rstmid_async: ctrl %b addr %h be %h want zeros",
                     {making_request, mem_req, mem_we, buf_wr_en, buf_rd_en}, mem_addr, mem_be);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        obs_tx.delete(); mr_rises = 0;
        repeat (20) @(negedge clk);
        checks++; if (mr_rises !== 0 || obs_tx.size() !== 0) begin
            errors++; $display("FAIL rstmid_held_level: rises %0d tx %0d want 0 0", mr_rises,
                               obs_tx.size()); end
        read = 1'b0;
        run_request(1, 0, 32'h0500_0000, 32'h0, 70, 1, 128, 0, 1, 0, to);
        build_model(1, 0, 32'h0500_0000, 32'h0, 70, 1, 128, 0);
        diff_results(bt, bb);
        checks++; if (to || obs_tx.size() !== 6 || bt !== 0) begin
            errors++; $display("FAIL rstmid_rearm: got %0d (%0d bad) want 6", obs_tx.size(), bt); end
    endtask

    task automatic test_zero_width();
        bit to;
        run_request(1, 0, 32'h1234_0000, 32'h0, 0, 5, 64, 0, 0, 0, to);
        checks++; if (to || mr_high !== 1) begin
            errors++; $display("FAIL zero_width_busy: got %0d cycles want 1", mr_high); end
        checks++; if (obs_tx.size() !== 0) begin
            errors++; $display("FAIL zero_width_req: got %0d want 0", obs_tx.size()); end
    endtask

    task automatic test_clamp();
        bit to; int bt, bb;
        run_request(1, 1, 32'hFFFF_FF00, 32'hFFFF_F000, 700, 15, 600, 520, 0, 0, to);
        build_model(1, 1, 32'hFFFF_FF00, 32'hFFFF_F000, 700, 15, 600, 520);
        diff_results(bt, bb);
        checks++; if (to || obs_tx.size() !== 144 || bt !== 0) begin
            errors++; $display("FAIL clamp_tx: got %0d (%0d bad) want 144", obs_tx.size(), bt); end
        checks++; if (obs_bw.size() !== 80 || bb !== 0) begin
            errors++; $display("FAIL clamp_bufwr: got %0d (%0d bad) want 80", obs_bw.size(), bb); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 10; it++) begin
            bit to, rd, wr; int bt, bb, w, h, irw, orw, dly;
            logic [31:0] ra, wa;
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            w = $urandom_range(0, 600); h = $urandom_range(0, 11);
            irw = $urandom_range(0, 524287); orw = $urandom_range(0, 524287);
            dly = $urandom_range(0, 3);
            ra = $urandom; wa = $urandom;
            run_request(rd, wr, ra, wa, w, h, irw, orw, dly, 0, to);
            build_model(rd, wr, ra, wa, w, h, irw, orw);
            diff_results(bt, bb);
            checks++;
            if (to || obs_tx.size() !== exp_tx.size() || bt !== 0) begin
                errors++;
                $display("FAIL random_tx[%0d]: got %0d (%0d bad) want %0d", it, obs_tx.size(), bt,
                         exp_tx.size());
            end
            checks++;
            if (obs_bw.size() !== exp_bw.size() || bb !== 0 || idle_viol !== 0) begin
                errors++;
                $display("FAIL random_bufwr[%0d]: got %0d (%0d bad, %0d idle) want %0d", it,
                         obs_bw.size(), bb, idle_viol, exp_bw.size());
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_read_write();
        test_ack_delay();
        test_reset_mid();
        test_zero_width();
        test_clamp();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_request_engine.md
FPU_REQUEST_ENGINE -- requirements
Module: fpu_request_engine

Interface
REQ-001 Parameter COL_WIDTH, default 10: rows held per column buffer; max read rows per request.
REQ-002 Parameter MEM_BUFFER_WIDTH, default 512: max bytes per buffer row; beats per row = MEM_BUFFER_WIDTH/64.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 read, write  in  1 each  request strobes from the FPU controller.
REQ-006 read_address, write_address  in  32  byte address of the first row of the read and write regions.
REQ-007 width  in  $clog2(MEM_BUFFER_WIDTH)+1  bytes per row to move.
REQ-008 height  in  $clog2(COL_WIDTH)+1  output rows; the read phase moves height+2 rows.
REQ-009 input_row_width, output_row_width  in  19  row stride in bytes for the read and write regions.
REQ-010 making_request  out  1  high while a request is in progress.
REQ-011 mem_req, mem_we  out  1 each; mem_addr  out  32; mem_be  out  64; mem_wdata  out  512; mem_ack  in  1; mem_rdata  in  512; mem_rvalid  in  1.
REQ-012 buf_wr_en  out  1; buf_wr_row  out  $clog2(COL_WIDTH); buf_wr_beat  out  3; buf_wr_data  out  512: load port to the read buffer.
REQ-013 buf_rd_en  out  1; buf_rd_row  out  $clog2(COL_WIDTH); buf_rd_beat  out  3; buf_rd_data  in  512, valid one cycle after buf_rd_en: drain port from the write buffer.

Function
REQ-014 Accept a request only in IDLE, on a 0->1 edge of (read|write) versus the previous cycle; a held-high level never re-triggers.
REQ-015 On accept, latch every request input; making_request rises the next cycle and stays high until FINISH.
REQ-016 FSM states: IDLE, RD_REQ, RD_WAIT, WR_FETCH, WR_CAP, WR_REQ, FINISH.
REQ-017 Phase order: read phase (if read latched and width != 0), then write phase (if write latched, width != 0 and height != 0), then FINISH; a skipped phase costs no cycles.
REQ-018 beats = ceil(width/64); beat address = row_base + 64*beat; row_base starts at the request address and adds the zero-extended stride per row; all address arithmetic is modulo 2^32.
REQ-019 mem_be is all ones except on the last beat of a row when width mod 64 != 0, where only the low (width mod 64) bits are set.
REQ-020 RD_REQ: mem_req=1, mem_we=0, with mem_addr/mem_be held stable until mem_ack; on ack go to RD_WAIT.
REQ-021 RD_WAIT: on mem_rvalid, pulse buf_wr_en for one cycle with row, beat and mem_rdata, then advance the beat (then the row); return to RD_REQ, or exit the phase after the last beat of row height+1.
REQ-022 WR_FETCH: buf_rd_en=1 for one cycle; WR_CAP: capture buf_rd_data into mem_wdata; WR_REQ: mem_req=1, mem_we=1 held until mem_ack, then advance; rows 0..height-1.
REQ-023 Single outstanding transaction; mem_rvalid outside RD_WAIT and mem_ack with mem_req low are ignored.
REQ-024 FINISH: making_request drops in the same cycle the FSM enters IDLE; a new edge in that cycle is not accepted.
REQ-025 height is clamped to COL_WIDTH-2 and width to MEM_BUFFER_WIDTH.
REQ-026 mem_req, buf_wr_en and buf_rd_en are registered outputs and never assert in IDLE.

Reset
REQ-027 rst asserted, including mid-transfer, immediately forces IDLE, making_request=0, mem_req=0, mem_we=0, buf_wr_en=0, buf_rd_en=0, mem_addr=0, mem_be=0, mem_wdata=0, all counters 0 and the edge-detect history 0.
REQ-028 After rst deasserts, a (read|write) level already high is not treated as an edge until it has been seen low.

Verification
REQ-029 read=1 held, read_address=0x1000_0000, width=130, height=8, input_row_width=390, mem_ack same cycle, rvalid +1 -> 30 reads (3 beats x 10 rows); row 1 beat 0 at 0x1000_0186; last-beat mem_be=0x3; 30 buf_wr_en pulses; exactly one request.
REQ-030 write only, write_address=0x2000_0000, width=64, height=8, output_row_width=388 -> 8 writes at 0x2000_0000 + 388*k, mem_be all ones, mem_wdata equal to the buffer data for row k, beat 0.
REQ-031 read and write together, width=512, height=2 -> 32 reads, then 16 writes; making_request is high throughout and drops once.
REQ-032 mem_ack delayed 5 cycles -> mem_addr, mem_be and mem_wdata are stable over all 5 cycles; no duplicate buf_wr_en.
REQ-033 rst pulsed during the 4th read beat -> all outputs at reset values asynchronously; read held high afterwards triggers nothing until it drops and rises.
REQ-034 width=0 with read=1 -> no mem_req; making_request high for exactly one cycle.
